// File: rtl/datapath_gen2_if.sv
// System data bus seen by the datapath: external value in, driven value, drive enable, conflict flag.
// Purely combinational wiring; no latency, no backpressure.
interface datapath_gen2_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              bus_conflict;

  modport master (input bus_in, output bus_out, output bus_oe, output bus_conflict);
  modport slave  (output bus_in, input bus_out, input bus_oe, input bus_conflict);
endinterface

// File: rtl/datapath_gen2.sv
// CPU datapath: GP regfile, latched ALU with flags, MAR/IR/JR, PC; DATAPATH_COND_JUMP_EN gates jumps on flags.
// Latency: reads/ALU/bus combinational, all state updates on the next clock edge.
// Backpressure: none; the control unit owns every strobe and the bus drive.
module datapath_gen2 #(
  parameter int                   DATA_W   = 8,
  parameter int                   GP_COUNT = 8,
  parameter logic [2*DATA_W-1:0]  RESET_PC = '0,
  localparam int                  SEL_W    = $clog2(GP_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  gp_write,
  input  logic                  gp_read,
  input  logic [SEL_W-1:0]      gp_input_select,
  input  logic [SEL_W-1:0]      gp_output_select,
  input  logic [SEL_W-1:0]      gp_alu_output_select,
  input  logic [3:0]            alu_operation,
  input  logic                  latch_alu,
  input  logic                  alu_store_high,
  input  logic                  alu_store_low,
  input  logic                  mar_load_high,
  input  logic                  mar_load_low,
  input  logic                  ir_load_high,
  input  logic                  ir_load_low,
  input  logic                  jr_load_high,
  input  logic                  jr_load_low,
  input  logic                  pc_increment,
  input  logic                  pc_set,
  input  logic                  pc_branch,
  input  logic [2:0]            jump_cond,
  datapath_gen2_if.master       bus,
  output logic [2:0]            flags,
  output logic [2*DATA_W-1:0]   pc_count,
  output logic [2*DATA_W-1:0]   ir_value,
  output logic [2*DATA_W-1:0]   mar_value
);
  localparam int AW   = 2 * DATA_W;
  localparam int NREG = 1 << SEL_W;

  logic [DATA_W-1:0] gp_q [NREG];
  logic [AW-1:0]     alu_latch, mar_q, ir_q, jr_q, pc_q;
  logic [2:0]        flags_q;

  logic [DATA_W-1:0] drv_dat, int_bus, op_a;
  logic [DATA_W:0]   ext;
  logic [AW-1:0]     alu_r;
  logic [2:0]        alu_flags;
  logic              is_mul, res_zero, res_neg, jump_ok;

  // gp_read wins over the latch halves; a losing driver still raises bus_conflict
  always_comb begin
    drv_dat = '0;
    if (gp_read)             drv_dat = gp_q[gp_output_select];
    else if (alu_store_low)  drv_dat = alu_latch[DATA_W-1:0];
    else if (alu_store_high) drv_dat = alu_latch[AW-1:DATA_W];
  end

  assign bus.bus_oe       = reset & (gp_read | alu_store_low | alu_store_high);
  assign bus.bus_out      = reset ? drv_dat : '0;
  assign bus.bus_conflict = reset & ((gp_read & alu_store_low) | (gp_read & alu_store_high) |
                                     (alu_store_low & alu_store_high));
  assign int_bus          = bus.bus_oe ? bus.bus_out : bus.bus_in;
  assign op_a             = gp_q[gp_alu_output_select];

  // ext carries {carry/borrow/shift-out, low result} for every non-multiply op
  always_comb begin
    ext = '0;
    case (alu_operation)
      4'd0:    ext = {1'b0, int_bus};
      4'd1:    ext = {1'b0, op_a} + {1'b0, int_bus};
      4'd2:    ext = {1'b0, op_a} - {1'b0, int_bus};
      4'd3:    ext = {1'b0, op_a & int_bus};
      4'd4:    ext = {1'b0, op_a | int_bus};
      4'd5:    ext = {1'b0, op_a ^ int_bus};
      4'd6:    ext = {1'b0, ~op_a};
      4'd7:    ext = {op_a, 1'b0};
      4'd8:    ext = {op_a[0], 1'b0, op_a[DATA_W-1:1]};
      4'd9:    ext = {1'b0, op_a} + {{DATA_W{1'b0}}, 1'b1};
      4'd10:   ext = {1'b0, op_a} - {{DATA_W{1'b0}}, 1'b1};
      default: ext = '0;
    endcase
  end

  assign is_mul    = (alu_operation == 4'd11);
  assign alu_r     = is_mul ? AW'(op_a) * AW'(int_bus) : {{(DATA_W-1){1'b0}}, ext};
  assign res_zero  = is_mul ? (alu_r == '0) : (alu_r[DATA_W-1:0] == '0);
  assign res_neg   = is_mul ? alu_r[AW-1] : alu_r[DATA_W-1];
  assign alu_flags = {ext[DATA_W], res_zero, res_neg};

`ifdef DATAPATH_COND_JUMP_EN
  // flags_q = {C, Z, N}; conditions test the flags already latched
  always_comb begin
    case (jump_cond)
      3'd0:    jump_ok = 1'b1;
      3'd1:    jump_ok = flags_q[1];
      3'd2:    jump_ok = !flags_q[1];
      3'd3:    jump_ok = flags_q[2];
      3'd4:    jump_ok = !flags_q[2];
      3'd5:    jump_ok = flags_q[0];
      3'd6:    jump_ok = !flags_q[0];
      default: jump_ok = 1'b0;
    endcase
  end
`else
  logic unused_jump_cond;
  assign unused_jump_cond = ^jump_cond;
  assign jump_ok          = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) gp_q[i] <= '0;
      alu_latch <= '0;
      flags_q   <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
      jr_q      <= '0;
      pc_q      <= RESET_PC;
    end else begin
      if (gp_write && (int'(gp_input_select) < GP_COUNT)) gp_q[gp_input_select] <= int_bus;
      if (latch_alu) begin
        alu_latch <= alu_r;
        flags_q   <= alu_flags;
      end
      if (mar_load_high) mar_q[AW-1:DATA_W] <= int_bus;
      if (mar_load_low)  mar_q[DATA_W-1:0]  <= int_bus;
      if (ir_load_high)  ir_q[AW-1:DATA_W]  <= int_bus;
      if (ir_load_low)   ir_q[DATA_W-1:0]   <= int_bus;
      if (jr_load_high)  jr_q[AW-1:DATA_W]  <= int_bus;
      if (jr_load_low)   jr_q[DATA_W-1:0]   <= int_bus;
      // a suppressed jump falls through to the increment
      if (pc_set && jump_ok)         pc_q <= jr_q;
      else if (pc_branch && jump_ok) pc_q <= pc_q + {{DATA_W{int_bus[DATA_W-1]}}, int_bus};
      else if (pc_increment)         pc_q <= pc_q + 1'b1;
    end
  end

  assign flags     = flags_q;
  assign pc_count  = pc_q;
  assign ir_value  = ir_q;
  assign mar_value = mar_q;
endmodule

// File: tb/tb_datapath_gen2.sv
// Bench for datapath_gen2: vector table, directed corner sequences and random stimulus against a reference model.
module tb_datapath_gen2;
  localparam int          DW  = 8;
  localparam logic [15:0] RPC = 16'h0100;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic gp_write, gp_read, latch_alu, alu_store_high, alu_store_low;
  logic mar_load_high, mar_load_low, ir_load_high, ir_load_low, jr_load_high, jr_load_low;
  logic pc_increment, pc_set, pc_branch;
  logic [2:0] gp_input_select, gp_output_select, gp_alu_output_select, jump_cond;
  logic [3:0] alu_operation;
  logic [7:0] bus_in;
  logic [2:0] flags;
  logic [15:0] pc_count, ir_value, mar_value;

  datapath_gen2_if #(.DATA_W(DW)) bus ();
  assign bus.bus_in = bus_in;

  datapath_gen2 #(.DATA_W(DW), .GP_COUNT(8), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .gp_write(gp_write), .gp_read(gp_read),
    .gp_input_select(gp_input_select), .gp_output_select(gp_output_select),
    .gp_alu_output_select(gp_alu_output_select), .alu_operation(alu_operation),
    .latch_alu(latch_alu), .alu_store_high(alu_store_high), .alu_store_low(alu_store_low),
    .mar_load_high(mar_load_high), .mar_load_low(mar_load_low),
    .ir_load_high(ir_load_high), .ir_load_low(ir_load_low),
    .jr_load_high(jr_load_high), .jr_load_low(jr_load_low),
    .pc_increment(pc_increment), .pc_set(pc_set), .pc_branch(pc_branch),
    .jump_cond(jump_cond), .bus(bus),
    .flags(flags), .pc_count(pc_count), .ir_value(ir_value), .mar_value(mar_value)
  );

  always #5 clock = ~clock;

  int n_run = 0;
  int n_fail = 0;
  int m_gp [8];
  int m_latch, m_flags, m_mar, m_ir, m_jr, m_pc;

  typedef struct { int op; int a; int b; int r; int fl; } vec_t;
  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_gp[i]) m_gp[i] = 0;
    m_latch = 0; m_flags = 0; m_mar = 0; m_ir = 0; m_jr = 0; m_pc = RPC;
  endtask

  // flags encoded as C*4 + Z*2 + N
  function automatic void alu_ref(input int op, input int a, input int b, output int r, output int fl);
    int t, c, lo, z, n;
    c = 0;
    case (op)
      0: t = b;
      1: begin t = a + b; c = (t > 255); end
      2: begin t = a - b; c = (t < 0); end
      3: t = a & b;
      4: t = a | b;
      5: t = a ^ b;
      6: t = 255 - a;
      7: begin t = a * 2; c = (t > 255); end
      8: begin t = a / 2; c = a % 2; end
      9: begin t = a + 1; c = (t > 255); end
      10: begin t = a - 1; c = (t < 0); end
      11: t = a * b;
      default: t = 0;
    endcase
    if (op == 11) begin
      r = t; z = (t == 0); n = (t >= 32768);
    end else begin
      lo = t & 255; r = c * 256 + lo; z = (lo == 0); n = (lo >= 128);
    end
    fl = c * 4 + z * 2 + n;
  endfunction

  function automatic bit jump_taken(input int cond, input int fl);
`ifdef DATAPATH_COND_JUMP_EN
    bit c, z, n;
    c = fl[2]; z = fl[1]; n = fl[0];
    case (cond)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      5: return n;
      6: return !n;
      default: return 1'b0;
    endcase
`else
    return (cond >= 0) || (fl >= 0);
`endif
  endfunction

  task automatic idle();
    gp_write = 0; gp_read = 0; latch_alu = 0; alu_store_high = 0; alu_store_low = 0;
    mar_load_high = 0; mar_load_low = 0; ir_load_high = 0; ir_load_low = 0;
    jr_load_high = 0; jr_load_low = 0; pc_increment = 0; pc_set = 0; pc_branch = 0;
    gp_input_select = 0; gp_output_select = 0; gp_alu_output_select = 0;
    jump_cond = 0; alu_operation = 0; bus_in = 0;
  endtask

  // Checks combinational outputs for the current inputs, clocks once, then checks state.
  task automatic step();
    int drv, ob, ib, r, fl, sx, npc;
    #1;
    drv = int'(gp_read) + int'(alu_store_low) + int'(alu_store_high);
    ob  = gp_read ? m_gp[gp_output_select] : alu_store_low ? (m_latch & 255) :
          alu_store_high ? (m_latch / 256) : 0;
    ib  = (drv > 0) ? ob : int'(bus_in);
    chk("bus_oe", {31'd0, bus.bus_oe}, (drv > 0) ? 1 : 0);
    chk("bus_conflict", {31'd0, bus.bus_conflict}, (drv >= 2) ? 1 : 0);
    if (drv > 0) chk("bus_out", {24'd0, bus.bus_out}, ob);
    alu_ref(int'(alu_operation), m_gp[gp_alu_output_select], ib, r, fl);
    sx  = (ib >= 128) ? ib - 256 : ib;
    npc = m_pc;
    if (pc_set && jump_taken(int'(jump_cond), m_flags))         npc = m_jr;
    else if (pc_branch && jump_taken(int'(jump_cond), m_flags)) npc = (m_pc + sx) & 32'hFFFF;
    else if (pc_increment)                                      npc = (m_pc + 1) & 32'hFFFF;
    @(posedge clock);
    #2;
    if (gp_write) m_gp[gp_input_select] = ib;
    if (latch_alu) begin m_latch = r; m_flags = fl; end
    if (mar_load_high) m_mar = (m_mar & 255) + ib * 256;
    if (mar_load_low)  m_mar = (m_mar & 32'hFF00) + ib;
    if (ir_load_high)  m_ir  = (m_ir & 255) + ib * 256;
    if (ir_load_low)   m_ir  = (m_ir & 32'hFF00) + ib;
    if (jr_load_high)  m_jr  = (m_jr & 255) + ib * 256;
    if (jr_load_low)   m_jr  = (m_jr & 32'hFF00) + ib;
    m_pc = npc;
    chk("pc_count", {16'd0, pc_count}, m_pc);
    chk("flags", {29'd0, flags}, m_flags);
    chk("mar_value", {16'd0, mar_value}, m_mar);
    chk("ir_value", {16'd0, ir_value}, m_ir);
  endtask

  task automatic wr_gp(input int sel, input int val);
    idle(); gp_write = 1; gp_input_select = 3'(sel); bus_in = 8'(val); step();
  endtask

  task automatic load_jr(input int val);
    idle(); jr_load_high = 1; bus_in = 8'(val >> 8); step();
    idle(); jr_load_low = 1; bus_in = 8'(val); step();
  endtask

  task automatic latch_bus(input int op, input int val);
    idle(); latch_alu = 1; alu_operation = 4'(op); bus_in = 8'(val); step();
  endtask

  initial begin
    vecs[0]  = '{1,  'h7F, 'h01, 'h0080, 'b001};
    vecs[1]  = '{2,  'h00, 'h01, 'h01FF, 'b101};
    vecs[2]  = '{11, 'hFF, 'hFF, 'hFE01, 'b001};
    vecs[3]  = '{0,  'h12, 'h00, 'h0000, 'b010};
    vecs[4]  = '{3,  'hF0, 'h3C, 'h0030, 'b000};
    vecs[5]  = '{4,  'hF0, 'h0F, 'h00FF, 'b001};
    vecs[6]  = '{5,  'hAA, 'hAA, 'h0000, 'b010};
    vecs[7]  = '{6,  'h0F, 'h00, 'h00F0, 'b001};
    vecs[8]  = '{7,  'h81, 'h00, 'h0102, 'b100};
    vecs[9]  = '{8,  'h01, 'h00, 'h0100, 'b110};
    vecs[10] = '{9,  'hFF, 'h00, 'h0100, 'b110};
    vecs[11] = '{10, 'h00, 'h00, 'h01FF, 'b101};
    vecs[12] = '{12, 'h55, 'h33, 'h0000, 'b010};
    vecs[13] = '{11, 'h10, 'h10, 'h0100, 'b000};

    idle();
    model_reset();
    gp_read = 1; alu_store_low = 1; pc_increment = 1;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_pc", {16'd0, pc_count}, 32'h0100);
    chk("rst_flags", {29'd0, flags}, 0);
    chk("rst_bus_oe", {31'd0, bus.bus_oe}, 0);
    chk("rst_bus_out", {24'd0, bus.bus_out}, 0);
    chk("rst_conflict", {31'd0, bus.bus_conflict}, 0);
    chk("rst_mar", {16'd0, mar_value}, 0);
    idle();
    reset = 1;
    repeat (3) begin pc_increment = 1; step(); end
    chk("pc_inc3", {16'd0, pc_count}, 32'h0103);

    // Move/ALU sequence with operand B sourced from a GP register
    wr_gp(1, 'h7F); wr_gp(2, 'h01);
    idle(); gp_read = 1; gp_output_select = 2; gp_alu_output_select = 1;
    alu_operation = 1; latch_alu = 1; step();
    idle(); alu_store_low = 1; #1;
    chk("add_lo", {24'd0, bus.bus_out}, 32'h80);
    chk("add_flags", {29'd0, flags}, 32'b001);
    wr_gp(1, 'h00);
    idle(); gp_read = 1; gp_output_select = 2; gp_alu_output_select = 1;
    alu_operation = 2; latch_alu = 1; step();
    idle(); alu_store_low = 1; #1;
    chk("sub_lo", {24'd0, bus.bus_out}, 32'hFF);
    chk("sub_carry", {31'd0, flags[2]}, 1);

    for (int i = 0; i < 14; i++) begin
      wr_gp(1, vecs[i].a);
      idle(); gp_alu_output_select = 1; alu_operation = 4'(vecs[i].op);
      bus_in = 8'(vecs[i].b); latch_alu = 1; step();
      chk($sformatf("vec%0d_flags", i), {29'd0, flags}, vecs[i].fl);
      idle(); alu_store_high = 1; #1;
      chk($sformatf("vec%0d_hi", i), {24'd0, bus.bus_out}, vecs[i].r >> 8);
      alu_store_high = 0; alu_store_low = 1; #1;
      chk($sformatf("vec%0d_lo", i), {24'd0, bus.bus_out}, vecs[i].r & 255);
      idle();
    end

    // Jumps, wrap and JR-load/pc_set ordering
    load_jr('h1234);
    idle(); pc_set = 1; step();
    chk("pc_set", {16'd0, pc_count}, 32'h1234);
    idle(); pc_branch = 1; bus_in = 8'hFE; step();
    chk("pc_branch", {16'd0, pc_count}, 32'h1232);
    load_jr('hFFFF);
    idle(); pc_set = 1; step();
    idle(); pc_increment = 1; step();
    chk("pc_wrap", {16'd0, pc_count}, 0);
    idle(); jr_load_low = 1; bus_in = 8'h00; pc_set = 1; step();
    chk("pc_old_jr", {16'd0, pc_count}, 32'hFFFF);

    // Driver priority and conflict, then a one-cycle register move
    wr_gp(3, 'h55);
    latch_bus(0, 'hAA);
    idle(); gp_read = 1; gp_output_select = 3; alu_store_low = 1; #1;
    chk("prio_out", {24'd0, bus.bus_out}, 32'h55);
    chk("prio_conflict", {31'd0, bus.bus_conflict}, 1);
    gp_write = 1; gp_input_select = 5; step();
    idle(); gp_read = 1; gp_output_select = 5; #1;
    chk("move_gp5", {24'd0, bus.bus_out}, 32'h55);
    latch_bus(0, 'h3C);
    idle(); alu_store_low = 1; latch_alu = 1; alu_operation = 12; #1;
    chk("latch_store_old", {24'd0, bus.bus_out}, 32'h3C);
    step();
    idle(); alu_store_low = 1; #1;
    chk("latch_store_new", {24'd0, bus.bus_out}, 0);

    load_jr('h0010);
    idle(); pc_set = 1; step();
    load_jr('h1234);
    latch_bus(0, 'h01);
`ifdef DATAPATH_COND_JUMP_EN
    idle(); jump_cond = 1; pc_set = 1; pc_increment = 1; step();
    chk("cond_z0", {16'd0, pc_count}, 32'h0011);
    latch_bus(0, 'h00);
    idle(); jump_cond = 1; pc_set = 1; pc_increment = 1; step();
    chk("cond_z1", {16'd0, pc_count}, 32'h1234);
`else
    idle(); jump_cond = 7; pc_set = 1; pc_increment = 1; step();
    chk("uncond_jump", {16'd0, pc_count}, 32'h1234);
`endif

    for (int i = 0; i < 400; i++) begin
      idle();
      gp_write = ($urandom % 4 == 0); gp_read = ($urandom % 3 == 0);
      alu_store_low = ($urandom % 5 == 0); alu_store_high = ($urandom % 5 == 0);
      latch_alu = ($urandom % 2 == 0);
      mar_load_high = ($urandom % 6 == 0); mar_load_low = ($urandom % 6 == 0);
      ir_load_high = ($urandom % 6 == 0); ir_load_low = ($urandom % 6 == 0);
      jr_load_high = ($urandom % 6 == 0); jr_load_low = ($urandom % 6 == 0);
      pc_increment = ($urandom % 3 == 0); pc_set = ($urandom % 6 == 0);
      pc_branch = ($urandom % 5 == 0);
      gp_input_select = 3'($urandom); gp_output_select = 3'($urandom);
      gp_alu_output_select = 3'($urandom); alu_operation = 4'($urandom);
      jump_cond = 3'($urandom); bus_in = 8'($urandom);
      step();
    end

    // Asynchronous reset mid-cycle, increment held throughout
    idle(); pc_increment = 1;
    #1 reset = 0;
    #1;
    chk("arst_pc", {16'd0, pc_count}, 32'h0100);
    chk("arst_flags", {29'd0, flags}, 0);
    chk("arst_oe", {31'd0, bus.bus_oe}, 0);
    model_reset();
    @(posedge clock);
    #2;
    chk("arst_hold_pc", {16'd0, pc_count}, 32'h0100);
    reset = 1;
    step();
    chk("arst_release_pc", {16'd0, pc_count}, 32'h0101);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_gen2.md
# datapath_gen2

Parametrised second-generation CPU datapath: general-purpose register file, ALU with latched result and flags, MAR/IR/JR address-width registers and a program counter with absolute and PC-relative jumps. It sits between the control unit (which drives all strobes) and the system data bus. It generalises the 8-bit datapath to any byte width and register count. It adds a multiply, a relative branch, drive-conflict detection and optional flag-conditioned jumps.

## Interface
- DATA_W, 8, data bus and GP register width (≥4); address registers are 2*DATA_W wide
- GP_COUNT, 8, number of GP registers (2..16); select ports are $clog2(GP_COUNT) bits
- RESET_PC, 0, PC value after reset
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- gp_write / gp_read  in  1  write selected GP from internal bus / drive selected GP onto bus
- gp_input_select, gp_output_select, gp_alu_output_select  in  SEL_W  write target / bus source / ALU operand A source
- alu_operation  in  4  opcode (see Operation)
- latch_alu, alu_store_high, alu_store_low  in  1  capture ALU result+flags / drive latched high / low half onto bus
- mar_load_high, mar_load_low, ir_load_high, ir_load_low, jr_load_high, jr_load_low  in  1  load half from internal bus
- pc_increment, pc_set, pc_branch  in  1  PC+1 / PC←JR / PC←PC+sext(bus)
- jump_cond  in  3  condition for pc_set/pc_branch (macro-dependent)
- bus_in  in  DATA_W  external bus value
- bus_out  out  DATA_W  value driven by datapath; bus_oe  out  1  drive enable
- bus_conflict  out  1  more than one internal driver this cycle (combinational)
- flags  out  3  {carry, zero, negative}, latched
- pc_count, ir_value, mar_value  out  2*DATA_W

## Operation
- Internal bus = bus_oe ? bus_out : bus_in; feeds ALU operand B, GP write and all half-loads.
- Drive priority: gp_read > alu_store_low > alu_store_high; bus_oe = OR of all three; bus_conflict = two or more asserted.
- ALU (combinational, 2*DATA_W result R, A = GP[alu select], B = bus): 0 pass B; 1 A+B; 2 A−B; 3 AND; 4 OR; 5 XOR; 6 NOT A; 7 A<<1; 8 A>>1 (logical); 9 A+1; 10 A−1; 11 A*B unsigned full product; 12–15 R=0.
- Non-multiply ops: R low = result, R high = {0, carry}. Carry = carry-out for add/inc, borrow for sub/dec, shifted-out bit for shifts, else 0. Zero = (R low == 0); negative = R low MSB. For op 11, zero and negative are computed on the full R.
- latch_alu: latch ← R, flags ← computed flags. Otherwise both hold.
- Half-loads: high loads bits [2DW−1:DW], low loads [DW−1:0]. Both asserted in one cycle loads the bus into both halves.
- PC priority: pc_set > pc_branch > pc_increment. Branch offset is sign-extended to 2*DATA_W, and arithmetic wraps modulo 2^(2*DATA_W); 0xFFFF+1 → 0x0000 at DATA_W=8.

## Timing
- All state updates on rising clock edge; reads, ALU and bus_out are combinational.
- Reset (asynchronous, any time, mid-operation included): GP, latch, flags, MAR, IR, JR = 0; PC = RESET_PC. With reset low: bus_oe = 0, bus_out = 0, bus_conflict = 0.
- gp_read and gp_write in the same cycle perform a register move in one cycle. Same-index read-during-write returns the old value.
- A same-cycle JR load plus pc_set uses the old JR value. latch_alu plus alu_store_* drives the old latch value.
- Latency: GP write → readable next cycle; latch_alu → store next cycle; pc_set → pc_count updates at the same edge.

## Configuration
- DATAPATH_COND_JUMP_EN defined:
  - pc_set and pc_branch take effect only when jump_cond is satisfied by the current latched flags: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 never.
  - When the jump is suppressed, pc_increment (if asserted) applies.
- Not defined: jump_cond is ignored and jumps are unconditional.

## Test plan
- Reset: hold reset low with RESET_PC=0x0100 and clock running → PC=0x0100, flags=0, bus_oe=0; after release, pc_increment for 3 cycles → 0x0103.
- Move/ALU: write GP1=0x7F and GP2=0x01. Read GP2 onto bus, A=GP1, op 1, latch → store_low gives 0x80, flags={0,0,1}. Op 2 on 0x00−0x01 → 0xFF, carry=1.
- Multiply: A=0xFF, B=0xFF, op 11, latch → store_high 0xFE, store_low 0x01.
- Jumps: load JR=0x1234 in two cycles, then pc_set → PC=0x1234. pc_branch with bus=0xFE → 0x1232. PC=0xFFFF plus increment → 0x0000.
- Conflict/priority: assert gp_read (GP3=0x55) and alu_store_low (latch low=0xAA) together → bus_out=0x55, bus_conflict=1.
- With DATAPATH_COND_JUMP_EN: set zero flag to 0, jump_cond=1, pc_set plus pc_increment at PC=0x0010 → PC=0x0011. With flag Z=1 → PC=JR.
